register_file: RTL and testbench



---
 rtl/cpu_pkg.sv | 17 +
 rtl/register_file_read_port.sv | 29 ++
 rtl/register_file.sv | 70 +++++++
 tb/tb_register_file.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths and types for the RV64I core datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN      = 64;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xword_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/register_file_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_read_port
//  Description : Combinational read mux for the integer register file.
//                x0 and any read while reset is asserted return zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_read_port
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic              rst_n_i,
    input  reg_idx_t          idx_i,
    input  logic [XLEN-1:0]   regs_i [NREGS],
    output logic [XLEN-1:0]   data_o
);

    // Select the addressed register, forcing zero for x0 and during reset
    always_comb begin
        data_o = '0;
        if (rst_n_i && (idx_i != '0)) begin
            data_o = regs_i[idx_i];
        end
    end

endmodule : register_file_read_port
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : RV64I integer register file, x0..x31. Two combinational
//                read ports, one synchronous write port, x0 hardwired to 0.
//                No internal write-to-read bypass: forwarding lives outside.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  reg_idx_t          rd,
    input  logic [XLEN-1:0]   write_data,
    input  logic              we,
    input  reg_idx_t          rs1,
    output logic [XLEN-1:0]   data1,
    input  reg_idx_t          rs2,
    output logic [XLEN-1:0]   data2
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next-state of the array: only rd changes, and never x0
    always_comb begin
        regs_d = regs_q;
        if (we && (rd != '0)) begin
            regs_d[rd] = write_data;
        end
    end

    // Storage; reset is asynchronous so it clears without a clock edge and
    // dominates any write arriving at the same instant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    register_file_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_read_port1 (
        .rst_n_i (reset),
        .idx_i   (rs1),
        .regs_i  (regs_q),
        .data_o  (data1)
    );

    register_file_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_read_port2 (
        .rst_n_i (reset),
        .idx_i   (rs2),
        .regs_i  (regs_q),
        .data_o  (data2)
    );

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rd;
    logic [63:0] write_data;
    logic        we;
    logic [4:0]  rs1;
    logic [63:0] data1;
    logic [4:0]  rs2;
    logic [63:0] data2;

    int checks;
    int errors;

    logic [63:0] exp1_q [$];
    logic [63:0] exp2_q [$];
    logic [63:0] model  [32];

    register_file dut (
        .clk        (clk),
        .reset      (reset),
        .rd         (rd),
        .write_data (write_data),
        .we         (we),
        .rs1        (rs1),
        .data1      (data1),
        .rs2        (rs2),
        .data2      (data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single synchronous write launched from a falling edge
    task automatic do_write(input logic [4:0] idx, input logic [63:0] val);
        @(negedge clk);
        we = 1'b1; rd = idx; write_data = val;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] e;
        reset = 1'b0; we = 1'b0; rd = '0; write_data = '0; rs1 = 5'd5; rs2 = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        exp1_q.push_back(64'h0);
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL reset_in_progress data1 got %h want %h", data1, e); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp1_q.push_back(64'h0); exp2_q.push_back(64'h0);
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL reset_rs1_5 data1 got %h want %h", data1, e); end
        e = exp2_q.pop_front(); checks++;
        if (data2 !== e) begin errors++; $display("FAIL reset_rs2_31 data2 got %h want %h", data2, e); end
    endtask

    task automatic test_write_read();
        logic [63:0] e;
        do_write(5'd10, 64'hDEADBEEF_CAFEF00D);
        rs1 = 5'd10; rs2 = 5'd10;
        exp1_q.push_back(64'hDEADBEEF_CAFEF00D); exp2_q.push_back(64'hDEADBEEF_CAFEF00D);
        #1;
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL write_read data1 got %h want %h", data1, e); end
        e = exp2_q.pop_front(); checks++;
        if (data2 !== e) begin errors++; $display("FAIL write_read data2 got %h want %h", data2, e); end
    endtask

    task automatic test_x0();
        logic [63:0] e;
        do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        rs1 = 5'd0; rs2 = 5'd10;
        exp1_q.push_back(64'h0); exp2_q.push_back(64'hDEADBEEF_CAFEF00D);
        #1;
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL x0_write data1 got %h want %h", data1, e); end
        e = exp2_q.pop_front(); checks++;
        if (data2 !== e) begin errors++; $display("FAIL x0_other_reg data2 got %h want %h", data2, e); end
    endtask

    task automatic test_we_low();
        logic [63:0] e;
        do_write(5'd3, 64'h1);
        do_write(5'd4, 64'h2);
        @(negedge clk);
        we = 1'b0; rd = 5'd3; write_data = 64'h99;
        @(posedge clk);
        #1;
        rs1 = 5'd3; rs2 = 5'd4;
        exp1_q.push_back(64'h1); exp2_q.push_back(64'h2);
        #1;
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL we_low data1 got %h want %h", data1, e); end
        e = exp2_q.pop_front(); checks++;
        if (data2 !== e) begin errors++; $display("FAIL we_low data2 got %h want %h", data2, e); end
    endtask

    task automatic test_same_cycle();
        logic [63:0] e;
        do_write(5'd7, 64'h11);
        @(negedge clk);
        we = 1'b1; rd = 5'd7; write_data = 64'h22; rs1 = 5'd7; rs2 = 5'd7;
        exp1_q.push_back(64'h11); exp2_q.push_back(64'h11);
        #1;
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL same_cycle_before data1 got %h want %h", data1, e); end
        e = exp2_q.pop_front(); checks++;
        if (data2 !== e) begin errors++; $display("FAIL same_cycle_before data2 got %h want %h", data2, e); end
        exp1_q.push_back(64'h22);
        @(posedge clk);
        #1;
        we = 1'b0;
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL same_cycle_after data1 got %h want %h", data1, e); end
    endtask

    task automatic test_async_reset();
        logic [63:0] e;
        do_write(5'd12, 64'hABCD);
        rs1 = 5'd12; rs2 = 5'd10;
        #1;
        exp1_q.push_back(64'hABCD);
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL async_pre data1 got %h want %h", data1, e); end
        // Assert reset between edges, then sample before the next rising edge
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp1_q.push_back(64'h0); exp2_q.push_back(64'h0);
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL async_clear data1 got %h want %h", data1, e); end
        e = exp2_q.pop_front(); checks++;
        if (data2 !== e) begin errors++; $display("FAIL async_clear data2 got %h want %h", data2, e); end
        // A write attempted while reset is held must be dropped
        we = 1'b1; rd = 5'd12; write_data = 64'h77;
        @(posedge clk);
        #1;
        @(negedge clk);
        we = 1'b0; reset = 1'b1;
        #1;
        exp1_q.push_back(64'h0);
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL write_during_reset data1 got %h want %h", data1, e); end
        // First edge after release accepts a write
        we = 1'b1; rd = 5'd12; write_data = 64'h5;
        @(posedge clk);
        #1;
        we = 1'b0;
        exp1_q.push_back(64'h5);
        e = exp1_q.pop_front(); checks++;
        if (data1 !== e) begin errors++; $display("FAIL post_reset_write data1 got %h want %h", data1, e); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        model[12] = 64'h5;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            rd = 5'($urandom);
            write_data = {$urandom, $urandom};
            rs1 = (n % 5 == 0) ? rd : 5'($urandom);
            rs2 = (n % 7 == 0) ? rs1 : 5'($urandom);
            if (we && rd != 5'd0) model[rd] = write_data;
            exp1_q.push_back(model[rs1]);
            exp2_q.push_back(model[rs2]);
            @(posedge clk);
            #1;
            e = exp1_q.pop_front(); checks++;
            if (data1 !== e) begin errors++; $display("FAIL b2b_data1 iter %0d rs1 %0d got %h want %h", n, rs1, data1, e); end
            e = exp2_q.pop_front(); checks++;
            if (data2 !== e) begin errors++; $display("FAIL b2b_data2 iter %0d rs2 %0d got %h want %h", n, rs2, data2, e); end
        end
        we = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_x0();
        test_we_low();
        test_same_cycle();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
